// File: rtl/cam_frame_tx.sv
// cam_frame_tx: replays an RGB332 frame buffer as an RGB565 camera parallel bus (vsync/href/px_data)
module cam_frame_tx #(
    parameter int AW       = 15,
    parameter int H_ACTIVE = 160,
    parameter int V_ACTIVE = 120,
    parameter int H_BLANK  = 16,
    parameter int VS_CYC   = 8,
    parameter int VBP_CYC  = 8
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          en,
    input  logic [7:0]    mem_rd_data,
    output logic [AW-1:0] mem_rd_addr,
    output logic          mem_rd_en,
    output logic          vsync,
    output logic          href,
    output logic [7:0]    px_data,
    output logic          frame_done
);
    localparam int A_LEN = 2 * H_ACTIVE;
    localparam int M1    = A_LEN > H_BLANK ? A_LEN : H_BLANK;
    localparam int M2    = VS_CYC > VBP_CYC ? VS_CYC : VBP_CYC;
    localparam int CMAX  = M1 > M2 ? M1 : M2;
    localparam int CW    = $clog2(CMAX);
    localparam int LW    = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0] VS_END  = CW'(VS_CYC - 1);
    localparam logic [CW-1:0] VBP_END = CW'(VBP_CYC - 1);
    localparam logic [CW-1:0] VBP_RD  = CW'(VBP_CYC - 2);
    localparam logic [CW-1:0] ACT_END = CW'(A_LEN - 1);
    localparam logic [CW-1:0] ACT_RD  = CW'(A_LEN - 2);
    localparam logic [CW-1:0] HB_END  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] HB_RD   = CW'(H_BLANK - 2);
    localparam logic [LW-1:0] LINE_END = LW'(V_ACTIVE - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK} state_t;

    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_en_q, rd_en_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic          done_q, done_d;
    logic [7:0]    px_q, px_d;
    logic          rvld_q;
    logic [7:0]    b1_q;
    logic [7:0]    x0, x1;

    assign mem_rd_addr = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign vsync       = vsync_q;
    assign href        = href_q;
    assign px_data     = px_q;
    assign frame_done  = done_q;

    // RGB332 -> RGB565 byte pair, bit-replicated so re-capture is lossless
    assign x0 = {mem_rd_data[7:5], mem_rd_data[7:6], mem_rd_data[4:2]};
    assign x1 = {mem_rd_data[4:2], mem_rd_data[1:0], mem_rd_data[1:0], mem_rd_data[1]};

    // next state and next registered outputs; reads run two cycles ahead of byte0
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q + 1'b1;
        line_d = line_q;
        case (st_q)
            S_IDLE: begin
                cnt_d = '0;
                st_d  = en ? S_VSYNC : S_IDLE;
            end
            S_VSYNC: if (cnt_q == VS_END) begin
                st_d  = S_VBP;
                cnt_d = '0;
            end
            S_VBP: if (cnt_q == VBP_END) begin
                st_d   = S_ACTIVE;
                cnt_d  = '0;
                line_d = '0;
            end
            S_ACTIVE: if (cnt_q == ACT_END) begin
                st_d  = S_HBLANK;
                cnt_d = '0;
            end
            S_HBLANK: if (cnt_q == HB_END) begin
                cnt_d = '0;
                if (line_q == LINE_END) begin
                    st_d = en ? S_VSYNC : S_IDLE;
                end else begin
                    st_d   = S_ACTIVE;
                    line_d = line_q + 1'b1;
                end
            end
            default: begin
                st_d  = S_IDLE;
                cnt_d = '0;
            end
        endcase
        rd_en_d = (st_d == S_VBP && cnt_d == VBP_RD)
               || (st_d == S_ACTIVE && !cnt_d[0] && cnt_d < ACT_RD)
               || (st_d == S_HBLANK && cnt_d == HB_RD && line_d != LINE_END);
        vsync_d = st_d == S_VSYNC;
        href_d  = st_d == S_ACTIVE;
        done_d  = st_d == S_HBLANK && cnt_d == '0 && line_d == LINE_END;
        addr_d  = (st_d == S_IDLE || st_d == S_VSYNC) ? '0 : rd_en_q ? addr_q + 1'b1 : addr_q;
        px_d    = !href_d ? 8'h00 : rvld_q ? x0 : b1_q;
    end

    // state, counters and all bus outputs registered together so they stay aligned
    always_ff @(posedge pclk) begin
        if (rst) begin
            st_q    <= S_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            done_q  <= 1'b0;
            px_q    <= 8'h00;
            rvld_q  <= 1'b0;
            b1_q    <= 8'h00;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            done_q  <= done_d;
            px_q    <= px_d;
            rvld_q  <= rd_en_q;
            if (rvld_q) b1_q <= x1;
        end
    end
endmodule

// File: tb/tb_cam_frame_tx.sv
// tb_cam_frame_tx: random frame-buffer replay checked against a per-cycle raster model
module tb_cam_frame_tx;
    localparam int AW  = 4;
    localparam int H   = 4;
    localparam int V   = 3;
    localparam int HB  = 2;
    localparam int VS  = 3;
    localparam int VBP = 2;
    localparam int LP  = 2 * H + HB;
    localparam int P   = VS + VBP + V * LP;
    localparam int N   = H * V;

    logic          pclk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [7:0]    mem_rd_data = 8'h00;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_en;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic          frame_done;
    logic [7:0]    mem [16];
    int            errs = 0;
    int            checks = 0;

    cam_frame_tx #(.AW(AW), .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .VS_CYC(VS), .VBP_CYC(VBP)) dut (
        .pclk(pclk), .rst(rst), .en(en), .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr),
        .mem_rd_en(mem_rd_en), .vsync(vsync), .href(href), .px_data(px_data), .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 32'({vsync, href, frame_done, mem_rd_en, px_data, mem_rd_addr}), 32'd0);
    endtask

    function automatic logic [7:0] xb(input logic [7:0] d, input bit odd);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = {d[7:5], d[7:6]};
        g6 = {d[4:2], d[4:2]};
        b5 = {d[1:0], d[1:0], d[1]};
        return odd ? {g6[2:0], b5} : {r5, g6[5:3]};
    endfunction

    task automatic run_frames(input int nf, input int drop_at);
        logic [7:0] tbl [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
        int strobes = 0;
        int dones = 0;
        logic [7:0] b0 = 8'h00;
        for (int g = 0; g < nf * P; g++) begin
            int i, j, k, ln, c, p, ead;
            logic evs, ehr, edn, ere;
            logic [7:0] epx;
            step();
            i = g % P;
            evs = i < VS;
            ehr = 1'b0; edn = 1'b0; epx = 8'h00; ere = 1'b0; ead = 0; p = 0; c = 0;
            j = i - VS - VBP;
            if (j >= 0) begin
                ln = j / LP;
                c = j % LP;
                p = ln * H + c / 2;
                if (ln < V && c < 2 * H) begin
                    ehr = 1'b1;
                    epx = xb(mem[p], c[0]);
                end
                edn = ln == V - 1 && c == 2 * H;
            end
            k = i + 2 - VS - VBP;
            if (k >= 0 && k / LP < V && k % LP < 2 * H && k % 2 == 0) begin
                ere = 1'b1;
                ead = (k / LP) * H + (k % LP) / 2;
            end
            chk("vsync", 32'(vsync), 32'(evs));
            chk("href", 32'(href), 32'(ehr));
            chk("frame_done", 32'(frame_done), 32'(edn));
            chk("px_data", 32'(px_data), 32'(epx));
            chk("rd_en", 32'(mem_rd_en), 32'(ere));
            if (ere) chk("rd_addr", 32'(mem_rd_addr), ead);
            if (g < P && j >= 0 && j < 8) chk("expand", 32'(px_data), 32'(tbl[j]));
            if (ehr && !c[0]) b0 = px_data;
            if (ehr && c[0]) chk("recapture", 32'({b0[7:5], b0[2:0], px_data[4:3]}), 32'(mem[p]));
            strobes += int'(mem_rd_en);
            dones += int'(frame_done);
            if (i == P - 1) begin
                chk("strobes", strobes, N);
                chk("dones", dones, 1);
                strobes = 0;
                dones = 0;
            end
            if (g == drop_at) en = 1'b0;
        end
    endtask

    initial begin
        for (int p = 0; p < 16; p++) mem[p] = 8'($urandom);
        mem[0] = 8'hE0;
        mem[1] = 8'h1C;
        mem[2] = 8'h03;
        mem[3] = 8'hFF;
        repeat (3) step();
        chk_idle("reset");
        rst = 1'b0;
        repeat (4) begin
            step();
            chk_idle("idle");
        end
        en = 1'b1;
        run_frames(2, P + VS + VBP + LP + int'($urandom_range(0, LP - 1)));
        repeat (8) begin
            step();
            chk_idle("after_drop");
        end
        en = 1'b1;
        repeat (VS + VBP + 4) step();
        chk("mid_href", 32'(href), 32'd1);
        rst = 1'b1;
        en = 1'b0;
        step();
        chk_idle("rst_mid");
        repeat (2) step();
        rst = 1'b0;
        repeat (5) begin
            step();
            chk_idle("rst_idle");
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
